cf_palette_loader: RTL

Sequencer and bus arbiter sitting between the CPU memory router and the GBC colour file. On command it streams 128 palette bytes from a synchronous palette ROM into the colour file through the BCPS/BCPD and OCPS/OCPD register interface. While loading it owns the colour file's bus and stalls CPU accesses to the colour-file registers; when idle it forwards CPU traffic transparently.

---
 rtl/cf_palette_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cf_palette_loader.sv
// Palette loader and colour-file bus arbiter: streams 128 ROM bytes into BCPD/OCPD, stalling CPU colour-file accesses meanwhile.
// Optional CF_AUTOLOAD_EN: start one load automatically on the first idle cycle after reset.
module cf_palette_loader (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_START,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic [6:0]  O_ROM_ADDR,
  input  logic [7:0]  I_ROM_DATA,
  input  logic [15:0] I_CPU_ADDR,
  input  logic [7:0]  I_CPU_DATA,
  input  logic        I_CPU_WE_L,
  output logic        O_CPU_STALL,
  output logic [15:0] O_CF_ADDR,
  output logic [7:0]  O_CF_DATA,
  output logic        O_CF_WE_L
);

  // Colour-file register map (matches memdef.vh)
  localparam logic [15:0] BCPS = 16'hFF68;
  localparam logic [15:0] BCPD = 16'hFF69;
  localparam logic [15:0] OCPS = 16'hFF6A;
  localparam logic [15:0] OCPD = 16'hFF6B;
  localparam logic [7:0]  SEL_IDX0_AUTOINC = 8'h80;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEL_BG   = 3'd1,
    BG_DATA  = 3'd2,
    SEL_OBJ  = 3'd3,
    OBJ_DATA = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [6:0]  rom_addr_q, rom_addr_d;
  logic        start_eff;
  logic        cpu_hits_cf;

`ifdef CF_AUTOLOAD_EN
  logic autoload_q;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) autoload_q <= 1'b1;
    else         autoload_q <= 1'b0;
  end

  assign start_eff = I_START | autoload_q;
`else
  assign start_eff = I_START;
`endif

  assign cpu_hits_cf = (I_CPU_ADDR >= BCPS) && (I_CPU_ADDR <= OCPD);

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      rom_addr_q <= 7'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  // The ROM address always runs one byte ahead of the write being issued.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    case (state_q)
      IDLE: begin
        cnt_d      = 6'd0;
        rom_addr_d = 7'd0;
        if (start_eff) state_d = SEL_BG;
      end
      SEL_BG: begin
        state_d    = BG_DATA;
        cnt_d      = 6'd0;
        rom_addr_d = 7'd1;
      end
      BG_DATA: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = SEL_OBJ;
        else                rom_addr_d = rom_addr_q + 7'd1;
      end
      SEL_OBJ: begin
        state_d    = OBJ_DATA;
        cnt_d      = 6'd0;
        rom_addr_d = rom_addr_q + 7'd1;
      end
      OBJ_DATA: begin
        cnt_d      = cnt_q + 6'd1;
        rom_addr_d = rom_addr_q + 7'd1;
        if (cnt_q == 6'd63) state_d = DONE;
      end
      DONE: begin
        state_d    = IDLE;
        cnt_d      = 6'd0;
        rom_addr_d = 7'd0;
      end
      default: begin
        state_d    = IDLE;
        cnt_d      = 6'd0;
        rom_addr_d = 7'd0;
      end
    endcase
  end

  always_comb begin
    O_CF_ADDR   = I_CPU_ADDR;
    O_CF_DATA   = I_CPU_DATA;
    O_CF_WE_L   = I_CPU_WE_L;
    O_BUSY      = 1'b0;
    O_DONE      = 1'b0;
    O_CPU_STALL = 1'b0;
    case (state_q)
      SEL_BG: begin
        O_CF_ADDR   = BCPS;
        O_CF_DATA   = SEL_IDX0_AUTOINC;
        O_CF_WE_L   = 1'b0;
        O_BUSY      = 1'b1;
        O_CPU_STALL = cpu_hits_cf;
      end
      BG_DATA: begin
        O_CF_ADDR   = BCPD;
        O_CF_DATA   = I_ROM_DATA;
        O_CF_WE_L   = 1'b0;
        O_BUSY      = 1'b1;
        O_CPU_STALL = cpu_hits_cf;
      end
      SEL_OBJ: begin
        O_CF_ADDR   = OCPS;
        O_CF_DATA   = SEL_IDX0_AUTOINC;
        O_CF_WE_L   = 1'b0;
        O_BUSY      = 1'b1;
        O_CPU_STALL = cpu_hits_cf;
      end
      OBJ_DATA: begin
        O_CF_ADDR   = OCPD;
        O_CF_DATA   = I_ROM_DATA;
        O_CF_WE_L   = 1'b0;
        O_BUSY      = 1'b1;
        O_CPU_STALL = cpu_hits_cf;
      end
      DONE: begin
        O_DONE = 1'b1;
      end
      default: begin
        O_DONE = 1'b0;
      end
    endcase
  end

  assign O_ROM_ADDR = rom_addr_q;

endmodule
